// File: rtl/branch_unit_pkg.sv
// Types and decode helper shared by the branch unit.
`include "cmp.vh"

package branch_unit_pkg;

  typedef logic [`CMP_OP_WIDTH-1:0] cmp_op_t;

  // Decoded view of a branch instruction: which compare to run and whether
  // the encoding is a legal BRANCH at all.
  typedef struct packed {
    logic    illegal;
    cmp_op_t op;
  } br_decode_t;

  localparam int INSTR_BYTES = 4;

  // Illegal encodings (wrong opcode, funct3 010/011) fall back to BEQ so the
  // compare input is always a defined code.
  function automatic br_decode_t decode_branch(input logic [6:0] opcode,
                                               input logic [2:0] funct3);
    br_decode_t d;
    d.illegal = 1'b0;
    d.op      = `CMP_OP_BEQ;
    case (funct3)
      `F3_BEQ:  d.op = `CMP_OP_BEQ;
      `F3_BNE:  d.op = `CMP_OP_BNE;
      `F3_BLT:  d.op = `CMP_OP_BLT;
      `F3_BGE:  d.op = `CMP_OP_BGE;
      `F3_BLTU: d.op = `CMP_OP_BLTU;
      `F3_BGEU: d.op = `CMP_OP_BGEU;
      default:  d.illegal = 1'b1;
    endcase
    if (opcode != `OPC_BRANCH) begin
      d.illegal = 1'b1;
    end
    if (d.illegal) begin
      d.op = `CMP_OP_BEQ;
    end
    return d;
  endfunction

endpackage

// File: rtl/cmp.sv
// Combinational branch comparator: evaluates one CMP_OP_* condition on a, b.
`include "cmp.vh"

module cmp #(
  parameter int WIDTH = 32
) (
  input  logic [`CMP_OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     taken
);

  // Select the comparison named by op; unknown codes never take.
  always_comb begin
    taken = 1'b0;
    case (op)
      `CMP_OP_BEQ:  taken = (a == b);
      `CMP_OP_BNE:  taken = (a != b);
      `CMP_OP_BLT:  taken = ($signed(a) <  $signed(b));
      `CMP_OP_BGE:  taken = ($signed(a) >= $signed(b));
      `CMP_OP_BLTU: taken = (a <  b);
      `CMP_OP_BGEU: taken = (a >= b);
      default:      taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp.vh
// Shared compare-op encoding plus the BRANCH opcode and funct3 values, so the
// decoder and the cmp block agree on one set of constants.
`ifndef CMP_VH
`define CMP_VH

`define CMP_OP_WIDTH 3

`define CMP_OP_BEQ  3'd0
`define CMP_OP_BNE  3'd1
`define CMP_OP_BLT  3'd2
`define CMP_OP_BGE  3'd3
`define CMP_OP_BLTU 3'd4
`define CMP_OP_BGEU 3'd5

`define OPC_BRANCH 7'b1100011

`define F3_BEQ  3'b000
`define F3_BNE  3'b001
`define F3_BLT  3'b100
`define F3_BGE  3'b101
`define F3_BLTU 3'b110
`define F3_BGEU 3'b111

`endif

// File: rtl/branch_unit.sv
// Execute-stage branch unit: decodes a B-type instruction, resolves it with
// cmp, computes target / next PC, flags mispredicts, and registers the result
// in a single valid/ready stage feeding fetch redirect.
// Optional build macro BRANCH_UNIT_PERF_EN adds branch / mispredict counters.
`include "cmp.vh"

module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  input  logic             i_pred_taken,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic [WIDTH-1:0] o_target,
  output logic [WIDTH-1:0] o_next_pc,
  output logic             o_mispredict,
  output logic             o_illegal,
  output logic             o_misaligned
`ifdef BRANCH_UNIT_PERF_EN
  ,
  output logic [31:0]      o_br_cnt,
  output logic [31:0]      o_mispred_cnt
`endif
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(INSTR_BYTES);

  br_decode_t       dec;
  logic [12:0]      imm13;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] target_c;
  logic [WIDTH-1:0] seq_pc_c;
  logic [WIDTH-1:0] next_pc_c;
  logic             cmp_taken;
  logic             taken_c;
  logic             mispredict_c;
  logic             misaligned_c;
  logic             load;
  logic             unused_instr_bits;

  // Register fields (rs1/rs2 indices) are not needed here.
  assign unused_instr_bits = ^i_instr[24:15];

  assign dec      = decode_branch(i_instr[6:0], i_instr[14:12]);
  assign imm13    = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_sext = {{(WIDTH-13){imm13[12]}}, imm13};

  // Both adders wrap modulo 2^WIDTH.
  assign target_c = i_pc + imm_sext;
  assign seq_pc_c = i_pc + PC_STEP;

  cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .op    (dec.op),
    .a     (i_rs1),
    .b     (i_rs2),
    .taken (cmp_taken)
  );

  // Illegal encodings never take, never mispredict, never fault on alignment;
  // the trap path owns them.
  assign taken_c      = cmp_taken & ~dec.illegal;
  assign next_pc_c    = taken_c ? target_c : seq_pc_c;
  assign mispredict_c = ~dec.illegal & (taken_c ^ i_pred_taken);
  assign misaligned_c = ~dec.illegal & taken_c & target_c[1];

  // Handshake: a request transfers on an edge where i_valid && o_ready, a
  // result transfers where o_valid && i_ready; o_ready = !o_valid || i_ready so
  // a draining result and a new request can share one edge. Outputs are frozen
  // while o_valid && !i_ready. i_flush drops the held result and blocks loading.
  assign o_ready = !o_valid || i_ready;
  assign load    = i_valid && o_ready && !i_flush;

  // Result register: valid tracking plus the payload captured on load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_taken      <= 1'b0;
      o_target     <= RESET_PC;
      o_next_pc    <= RESET_PC;
      o_mispredict <= 1'b0;
      o_illegal    <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (load) begin
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (load) begin
        o_taken      <= taken_c;
        o_target     <= target_c;
        o_next_pc    <= next_pc_c;
        o_mispredict <= mispredict_c;
        o_illegal    <= dec.illegal;
        o_misaligned <= misaligned_c;
      end
    end
  end

`ifdef BRANCH_UNIT_PERF_EN
  logic result_hs;
  assign result_hs = o_valid && i_ready;

  // Count legal resolved branches and mispredicts as they leave the stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_br_cnt      <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (result_hs && !o_illegal) begin
        o_br_cnt <= o_br_cnt + 32'd1;
      end
      if (result_hs && o_mispredict) begin
        o_mispred_cnt <= o_mispred_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed + randomized bench for branch_unit with a scoreboard queue.
module tb_branch_unit;

  localparam int               W   = 32;
  localparam int               EW  = 4 + 2 * W;
  localparam logic [W-1:0]     RPC = 32'h80;
  localparam logic [6:0]       OPC = 7'b1100011;

  logic         clk;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [31:0]  i_instr;
  logic [W-1:0] i_pc;
  logic [W-1:0] i_rs1;
  logic [W-1:0] i_rs2;
  logic         i_pred_taken;
  logic         i_flush;
  logic         o_valid;
  logic         i_ready;
  logic         o_taken;
  logic [W-1:0] o_target;
  logic [W-1:0] o_next_pc;
  logic         o_mispredict;
  logic         o_illegal;
  logic         o_misaligned;
`ifdef BRANCH_UNIT_PERF_EN
  logic [31:0]  br_cnt;
  logic [31:0]  mispred_cnt;
`endif

  logic [EW-1:0] obs;
  logic [EW-1:0] cur_exp;
  logic [EW-1:0] exp_q[$];
  logic          mv;
  int            tests = 0;
  int            fails = 0;

  assign obs = {o_taken, o_mispredict, o_illegal, o_misaligned, o_target, o_next_pc};

  branch_unit #(
    .WIDTH    (W),
    .RESET_PC (RPC)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_instr      (i_instr),
    .i_pc         (i_pc),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .i_pred_taken (i_pred_taken),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_taken      (o_taken),
    .o_target     (o_target),
    .o_next_pc    (o_next_pc),
    .o_mispredict (o_mispredict),
    .o_illegal    (o_illegal),
    .o_misaligned (o_misaligned)
`ifdef BRANCH_UNIT_PERF_EN
    ,
    .o_br_cnt      (br_cnt),
    .o_mispred_cnt (mispred_cnt)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Reference: result fields packed as {taken, mispredict, illegal, misaligned, target, next_pc}.
  function automatic logic [EW-1:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [W-1:0] pc, input logic [W-1:0] rs1,
                                          input logic [W-1:0] rs2, input logic [12:0] imm,
                                          input logic pred);
    logic         ill;
    logic         res;
    logic         tk;
    logic [W-1:0] tgt;
    logic [W-1:0] nxt;
    ill = (opc != OPC);
    res = 1'b0;
    case (f3)
      3'd0: res = (rs1 == rs2);
      3'd1: res = (rs1 != rs2);
      3'd4: res = ($signed(rs1) < $signed(rs2));
      3'd5: res = ($signed(rs1) >= $signed(rs2));
      3'd6: res = (rs1 < rs2);
      3'd7: res = (rs1 >= rs2);
      default: ill = 1'b1;
    endcase
    tk  = !ill && res;
    tgt = pc + {{(W-13){imm[12]}}, imm};
    nxt = tk ? tgt : pc + 32'd4;
    return {tk, !ill && (tk != pred), ill, !ill && tk && tgt[1], tgt, nxt};
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] o, input logic [EW-1:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Driver: present a request and remember its expected result.
  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [W-1:0] pc,
                       input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                       input logic [12:0] imm, input logic pred);
    logic [31:0] ins;
    ins = enc(f3, imm);
    ins[6:0] = opc;
    i_instr      = ins;
    i_pc         = pc;
    i_rs1        = rs1;
    i_rs2        = rs2;
    i_pred_taken = pred;
    i_valid      = 1'b1;
    cur_exp      = model(opc, f3, pc, rs1, rs2, imm, pred);
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  // One cycle: check handshake signals, run the scoreboard, advance to posedge+1.
  task automatic step(output bit acc_o);
    logic pop;
    logic acc;
    @(negedge clk);
    acc_o = 1'b0;
    if (!i_rst) begin
      check("o_valid", o_valid, mv);
      check("o_ready", o_ready, !mv || i_ready);
      pop = mv && i_ready;
      acc = i_valid && !i_flush && (!mv || i_ready);
      if (pop) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL sb_empty: observed result %h expected none", obs);
        end else begin
          check("result", obs, exp_q.pop_front());
        end
      end else if (i_flush && mv && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(cur_exp);
      mv    = i_flush ? 1'b0 : acc ? 1'b1 : pop ? 1'b0 : mv;
      acc_o = acc;
    end else begin
      exp_q.delete();
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_taken"}, o_taken, 1'b0);
    check({tag, "_mispred"}, o_mispredict, 1'b0);
    check({tag, "_illegal"}, o_illegal, 1'b0);
    check({tag, "_misal"}, o_misaligned, 1'b0);
    check({tag, "_target"}, o_target, RPC);
    check({tag, "_next_pc"}, o_next_pc, RPC);
  endtask

  initial begin
    bit            acc;
    logic [EW-1:0] a_exp;
    logic [EW-1:0] b_exp;
    int            r;
    logic [2:0]    f3;
    logic [W-1:0]  ra;

    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_instr = '0; i_pc = '0; i_rs1 = '0; i_rs2 = '0; i_pred_taken = 1'b0;
    mv = 1'b0; cur_exp = '0;
    repeat (2) step(acc);
    i_rst = 1'b0;
    chk_reset("rst");
    check("rst_ready", o_ready, 1'b1);
`ifdef BRANCH_UNIT_PERF_EN
    check("rst_br_cnt", br_cnt, 32'd0);
    check("rst_mis_cnt", mispred_cnt, 32'd0);
`endif

    // 1: BEQ equal, predicted not-taken
    drive(OPC, 3'd0, 32'h100, 32'd13, 32'd13, 13'd16, 1'b0);
    step(acc); idle();
    check("t1_valid", o_valid, 1'b1);
    check("t1_taken", o_taken, 1'b1);
    check("t1_target", o_target, 32'h110);
    check("t1_next_pc", o_next_pc, 32'h110);
    check("t1_mispred", o_mispredict, 1'b1);
    step(acc);

    // 2: BLTU -12 vs 10 unsigned -> not taken
    drive(OPC, 3'd6, 32'h200, 32'hFFFF_FFF4, 32'd10, 13'h1FF8, 1'b0);
    step(acc); idle();
    check("t2_taken", o_taken, 1'b0);
    check("t2_next_pc", o_next_pc, 32'h204);
    check("t2_mispred", o_mispredict, 1'b0);
    step(acc);

    // 2b: BLT -22 vs 2 signed -> taken
    drive(OPC, 3'd4, 32'h300, 32'hFFFF_FFEA, 32'd2, 13'h040, 1'b1);
    step(acc); idle();
    check("t2b_taken", o_taken, 1'b1);
    check("t2b_target", o_target, 32'h340);
    check("t2b_mispred", o_mispredict, 1'b0);
    step(acc);

    // Back-to-back boundary cases at full throughput
    drive(OPC, 3'd0, 32'h10, 32'd5, 32'd6, 13'h1000, 1'b1); step(acc);
    drive(OPC, 3'd1, 32'h20, 32'd5, 32'd5, 13'd8, 1'b0); step(acc);
    drive(OPC, 3'd4, 32'h30, 32'h8000_0000, 32'h7FFF_FFFF, 13'd4, 1'b0); step(acc);
    drive(OPC, 3'd5, 32'h40, 32'h8000_0000, 32'h8000_0000, 13'h1FFC, 1'b1); step(acc);
    drive(OPC, 3'd6, 32'h50, 32'h8000_0000, 32'h7FFF_FFFF, 13'd12, 1'b1); step(acc);
    drive(OPC, 3'd7, 32'hFFFF_FFF0, 32'd0, 32'd0, 13'd32, 1'b1); step(acc);
    drive(OPC, 3'd5, 32'h60, 32'h7FFF_FFFF, 32'h8000_0000, 13'h0FFE, 1'b0); step(acc);
    idle(); step(acc);

    // Random requests with random downstream backpressure
    for (int i = 0; i < 16; i++) begin
      r  = $urandom_range(0, 5);
      f3 = (r < 2) ? 3'(r) : 3'(r + 2);
      ra = $urandom;
      drive(OPC, f3, {$urandom_range(0, 65535), 2'b00}, ra,
            ($urandom_range(0, 3) == 0) ? ra : W'($urandom),
            13'($urandom_range(0, 8191)) & 13'h1FFE, 1'($urandom_range(0, 1)));
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        i_ready = 1'($urandom_range(0, 1));
        step(acc);
      end
      check("rand_accept", acc, 1'b1);
    end
    idle(); i_ready = 1'b1;
    repeat (2) step(acc);

    // 3 / 3b: backpressure with a second request waiting upstream
    drive(OPC, 3'd1, 32'h400, 32'd1, 32'd2, 13'd32, 1'b1);
    a_exp = cur_exp;
    step(acc);
    drive(OPC, 3'd7, 32'h500, 32'd3, 32'd9, 13'd16, 1'b1);
    b_exp = cur_exp;
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check("t3_hold_out", obs, a_exp);
      check("t3_hold_noacc", acc, 1'b0);
    end
    i_ready = 1'b1;
    step(acc);
    check("t3b_accept", acc, 1'b1);
    idle();
    check("t3b_valid", o_valid, 1'b1);
    check("t3b_out", obs, b_exp);
    step(acc);
    check("t3b_sb_empty", exp_q.size(), 0);

    // 4: illegal funct3 and illegal opcode
    drive(OPC, 3'd2, 32'h700, 32'd4, 32'd4, 13'd2, 1'b1);
    step(acc); idle();
    check("t4_illegal", o_illegal, 1'b1);
    check("t4_taken", o_taken, 1'b0);
    check("t4_mispred", o_mispredict, 1'b0);
    step(acc);
    drive(7'b1100111, 3'd0, 32'h710, 32'd4, 32'd4, 13'd2, 1'b1);
    step(acc); idle();
    check("t4_opc_illegal", o_illegal, 1'b1);
    check("t4_opc_misal", o_misaligned, 1'b0);
    step(acc);

    // 4b: taken BGE to pc+2 -> misaligned
    drive(OPC, 3'd5, 32'h600, 32'd7, 32'd7, 13'd2, 1'b1);
    step(acc); idle();
    check("t4b_misal", o_misaligned, 1'b1);
    check("t4b_target", o_target, 32'h602);
    check("t4b_next_pc", o_next_pc, 32'h602);
    step(acc);

    // 5: flush with a held result and a new request
    i_ready = 1'b0;
    drive(OPC, 3'd0, 32'h800, 32'd1, 32'd1, 13'd8, 1'b0);
    step(acc);
    drive(OPC, 3'd1, 32'h900, 32'd1, 32'd2, 13'd8, 1'b0);
    i_flush = 1'b1;
    step(acc);
    idle();
    check("t5_valid", o_valid, 1'b0);
    i_ready = 1'b1;
    repeat (2) step(acc);
    check("t5_sb_empty", exp_q.size(), 0);

    // 5b: reset while holding
    i_ready = 1'b0;
    drive(OPC, 3'd4, 32'hA00, 32'hFFFF_FFFF, 32'd0, 13'd6, 1'b0);
    step(acc); idle();
    step(acc);
    i_rst = 1'b1;
    step(acc);
    i_rst = 1'b0;
    i_ready = 1'b1;
    chk_reset("t5b");

    // 6: 10 handshaken branches, 3 mispredicted, 1 illegal
    drive(OPC, 3'd0, 32'h1000, 32'd1, 32'd1, 13'd8, 1'b1); step(acc);
    drive(OPC, 3'd0, 32'h1004, 32'd1, 32'd2, 13'd8, 1'b1); step(acc);
    drive(OPC, 3'd1, 32'h1008, 32'd1, 32'd2, 13'd8, 1'b1); step(acc);
    drive(OPC, 3'd1, 32'h100C, 32'd1, 32'd1, 13'd8, 1'b1); step(acc);
    drive(OPC, 3'd4, 32'h1010, 32'd1, 32'd2, 13'd8, 1'b0); step(acc);
    drive(OPC, 3'd5, 32'h1014, 32'd1, 32'd2, 13'd8, 1'b0); step(acc);
    drive(OPC, 3'd6, 32'h1018, 32'd1, 32'd2, 13'd8, 1'b1); step(acc);
    drive(OPC, 3'd7, 32'h101C, 32'd1, 32'd2, 13'd8, 1'b0); step(acc);
    drive(OPC, 3'd3, 32'h1020, 32'd1, 32'd2, 13'd8, 1'b1); step(acc);
    drive(OPC, 3'd5, 32'h1024, 32'd2, 32'd1, 13'd8, 1'b1); step(acc);
    idle(); step(acc);
    check("t6_sb_empty", exp_q.size(), 0);
`ifdef BRANCH_UNIT_PERF_EN
    check("t6_br_cnt", br_cnt, 32'd9);
    check("t6_mis_cnt", mispred_cnt, 32'd3);
    i_rst = 1'b1;
    step(acc);
    i_rst = 1'b0;
    check("t6b_br_cnt", br_cnt, 32'd0);
    check("t6b_mis_cnt", mispred_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
